// File: rtl/truth_table_checker_pkg.sv
// rtl/truth_table_checker_pkg.sv - shared state encoding and sweep-length helpers for truth_table_checker
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ttc_state_e;

    localparam int TTC_DEF_IN_W = 5;
    localparam int TTC_DEF_N    = 1 << TTC_DEF_IN_W;

    // Sweep length N = 2**in_w; used where the top derives N from its own IN_W.
    function automatic int ttc_sweep_len(input int in_w);
        return 1 << in_w;
    endfunction

endpackage

// File: rtl/truth_table_checker_channel_stat.sv
// rtl/truth_table_checker_channel_stat.sv - per-channel mismatch statistics (ttc_channel_stat)
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : wipe statistics (sweep start)
//   cmp_valid    : a compare happens this cycle
//   mismatch     : this channel's result differs from the reference
//   idx          : vector index being compared
//   err_cnt      : number of mismatches seen
//   first_fail   : index of the first mismatch, 0 while fail is clear
//   fail         : at least one mismatch recorded
module ttc_channel_stat
    import truth_table_checker_pkg::*;
#(
    parameter int IN_W  = TTC_DEF_IN_W,
    parameter int CNT_W = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cmp_valid,
    input  logic             mismatch,
    input  logic [IN_W-1:0]  idx,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IN_W-1:0]  first_fail,
    output logic             fail
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            first_fail <= '0;
            fail       <= 1'b0;
        end else if (clear) begin
            err_cnt    <= '0;
            first_fail <= '0;
            fail       <= 1'b0;
        end else if (cmp_valid && mismatch) begin
            // CNT_W = IN_W+1 holds N, so no saturation is needed.
            err_cnt <= err_cnt + CNT_W'(1);
            if (!fail) begin
                first_fail <= idx;
                fail       <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive sweeper comparing CH combinational channels to a reference truth table
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a sweep (accepted in IDLE or DONE)
//   abort         : return to IDLE on the next edge, statistics kept
//   stop_on_fail  : end the sweep at the first mismatch (latched at start)
//   dut_in        : vector driven to every channel
//   dut_res       : channel results, bit c = channel c
//   busy / done   : sweep in progress / sweep finished
//   pass          : done with no mismatch on any channel
//   fail_mask     : per-channel "has failed" flags
//   err_cnt       : per-channel mismatch counts, channel c at [c*CNT_W +: CNT_W]
//   first_fail    : per-channel first failing vector, channel c at [c*IN_W +: IN_W]
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                    IN_W      = 5,
    parameter int                    CH        = 2,
    parameter int                    LAT       = 0,
    parameter logic [(1<<IN_W)-1:0]  REF_TABLE = 32'h52263ECD,
    parameter int                    CNT_W     = IN_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stop_on_fail,
    output logic [IN_W-1:0]       dut_in,
    input  logic [CH-1:0]         dut_res,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CH-1:0]         fail_mask,
    output logic [CH*CNT_W-1:0]   err_cnt,
    output logic [CH*IN_W-1:0]    first_fail
);

    localparam int              N    = ttc_sweep_len(IN_W);
    localparam logic [IN_W-1:0] LAST = IN_W'(N - 1);

    ttc_state_e      state, state_next;
    logic            clear;
    logic            stop_en;
    logic            stop_hit;
    logic [1:0]      drain_cnt;
    logic            cmp_valid;
    logic [IN_W-1:0] cmp_idx;
    logic [IN_W-1:0] ref_idx;
    logic            ref_bit;
    logic [CH-1:0]   mismatch;
    logic            upd;

    // The MSB of REF_TABLE belongs to vector 0.
    assign ref_idx  = LAST - cmp_idx;
    assign ref_bit  = REF_TABLE[ref_idx];
    assign mismatch = dut_res ^ {CH{ref_bit}};
    assign upd      = cmp_valid && !abort;
    assign stop_hit = stop_en && upd && (|mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        clear      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop_hit)
                        state_next = ST_DONE;
                    else if (dut_in == LAST)
                        state_next = (LAT > 0) ? ST_DRAIN : ST_DONE;
                end
                ST_DRAIN: begin
                    if (stop_hit || drain_cnt == 2'(LAT - 1))
                        state_next = ST_DONE;
                end
                ST_DONE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        clear      = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in    <= '0;
            drain_cnt <= '0;
            stop_en   <= 1'b0;
        end else begin
            if (clear)
                dut_in <= '0;
            else if (state == ST_RUN && state_next == ST_RUN)
                dut_in <= dut_in + IN_W'(1);
            drain_cnt <= (state == ST_DRAIN && state_next == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (clear)
                stop_en <= stop_on_fail;
        end
    end

    // Vector index travels LAT stages so it lines up with the DUT's delayed result.
    generate
        if (LAT == 0) begin : g_nopipe
            assign cmp_valid = (state == ST_RUN);
            assign cmp_idx   = dut_in;
        end else begin : g_pipe
            logic [LAT-1:0]  pipe_valid;
            logic [IN_W-1:0] pipe_idx [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_valid <= '0;
                    for (int i = 0; i < LAT; i++) pipe_idx[i] <= '0;
                end else if (abort || stop_hit || clear) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= (state == ST_RUN);
                    pipe_idx[0]   <= dut_in;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_idx[i]   <= pipe_idx[i-1];
                    end
                end
            end

            assign cmp_valid = pipe_valid[LAT-1];
            assign cmp_idx   = pipe_idx[LAT-1];
        end
    endgenerate

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            ttc_channel_stat #(
                .IN_W  (IN_W),
                .CNT_W (CNT_W)
            ) u_stat (
                .clk        (clk),
                .rst_n      (rst_n),
                .clear      (clear),
                .cmp_valid  (upd),
                .mismatch   (mismatch[c]),
                .idx        (cmp_idx),
                .err_cnt    (err_cnt[c*CNT_W +: CNT_W]),
                .first_fail (first_fail[c*IN_W +: IN_W]),
                .fail       (fail_mask[c])
            );
        end
    endgenerate

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done && (fail_mask == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker
module tb_truth_table_checker;

    localparam logic [31:0] REF = 32'h52263ECD;

    typedef struct {
        string      name;
        int         lat;
        logic       pass;
        logic [1:0] mask;
        bit         stats;
        int         e0, e1, f0, f1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start2, abort0, abort2, sof0, sof2;
    logic [4:0]  in0, in2;
    logic [1:0]  res0, res2;
    logic        busy0, done0, pass0, busy2, done2, pass2;
    logic [1:0]  mask0, mask2;
    logic [11:0] err0, err2;
    logic [9:0]  ff0, ff2;

    logic [31:0] flip0, flip1;
    logic [1:0]  tie0;
    logic        use_delay;
    logic        d0a, d0b, d2a, d2b;

    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   start_cyc0 = 0, start_cyc2 = 0;
    exp_t q0[$];
    exp_t q2[$];
    exp_t m0, m2;
    logic done0_q = 1'b0, done2_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_checker #(.IN_W(5), .CH(2), .LAT(0), .REF_TABLE(32'h52263ECD), .CNT_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .stop_on_fail(sof0),
        .dut_in(in0), .dut_res(res0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(mask0), .err_cnt(err0), .first_fail(ff0));

    truth_table_checker #(.IN_W(5), .CH(2), .LAT(2), .REF_TABLE(32'h52263ECD), .CNT_W(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .stop_on_fail(sof2),
        .dut_in(in2), .dut_res(res2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_mask(mask2), .err_cnt(err2), .first_fail(ff2));

    function automatic logic refb(input logic [4:0] v);
        return REF[5'd31 - v];
    endfunction

    // Channel models: reference with optional flipped vectors, tied-low, or a 2-stage registered copy.
    always @(posedge clk) begin
        d0a <= refb(in0);
        d0b <= d0a;
        d2a <= refb(in2);
        d2b <= d2a;
    end

    always_comb begin
        res0[0] = tie0[0] ? 1'b0 : (use_delay ? d0b : (refb(in0) ^ flip0[in0]));
        res0[1] = tie0[1] ? 1'b0 : (use_delay ? d0b : (refb(in0) ^ flip1[in0]));
        res2    = {2{d2b}};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input int lat, input logic p, input logic [1:0] m,
                                input bit st, input int e0, input int e1, input int f0, input int f1);
        exp_t e;
        e.name = nm; e.lat = lat; e.pass = p; e.mask = m; e.stats = st;
        e.e0 = e0; e.e1 = e1; e.f0 = f0; e.f1 = f1;
        return e;
    endfunction

    task automatic cmp_done(input exp_t e, input int lat, input logic p, input logic [1:0] m,
                            input logic [11:0] ec, input logic [9:0] ff);
        chk({e.name, ":latency"}, lat, e.lat);
        chk({e.name, ":pass"}, 32'(p), 32'(e.pass));
        chk({e.name, ":fail_mask"}, 32'(m), 32'(e.mask));
        if (e.stats) begin
            chk({e.name, ":err_cnt0"}, 32'(ec[5:0]), e.e0);
            chk({e.name, ":err_cnt1"}, 32'(ec[11:6]), e.e1);
            chk({e.name, ":first_fail0"}, 32'(ff[4:0]), e.f0);
            chk({e.name, ":first_fail1"}, 32'(ff[9:5]), e.f1);
        end
    endtask

    // Monitor: each rising done pops the next expectation for that checker.
    always @(negedge clk) begin
        if (done0 && !done0_q) begin
            if (q0.size() == 0) chk("unexpected_done0", 1, 0);
            else begin
                m0 = q0.pop_front();
                cmp_done(m0, cyc - start_cyc0, pass0, mask0, err0, ff0);
            end
        end
        if (done2 && !done2_q) begin
            if (q2.size() == 0) chk("unexpected_done2", 1, 0);
            else begin
                m2 = q2.pop_front();
                cmp_done(m2, cyc - start_cyc2, pass2, mask2, err2, ff2);
            end
        end
        done0_q <= done0;
        done2_q <= done2;
    end

    task automatic run(input int sel, input exp_t e, input logic sof, input int poke);
        bit ok;
        if (sel == 0) q0.push_back(e); else q2.push_back(e);
        @(negedge clk);
        if (sel == 0) begin start0 = 1'b1; sof0 = sof; end
        else          begin start2 = 1'b1; sof2 = sof; end
        @(posedge clk); #1;
        if (sel == 0) begin
            start_cyc0 = cyc;
            chk({e.name, ":start_busy"}, 32'(busy0), 1);
            chk({e.name, ":start_done_low"}, 32'(done0), 0);
            chk({e.name, ":start_cleared"}, 32'(err0), 0);
        end else begin
            start_cyc2 = cyc;
            chk({e.name, ":start_busy"}, 32'(busy2), 1);
            chk({e.name, ":start_done_low"}, 32'(done2), 0);
            chk({e.name, ":start_cleared"}, 32'(err2), 0);
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            start2 = 1'b0;
            if (sel == 0 && poke >= 0 && busy0 && int'(in0) == poke) start0 = 1'b1;
            if ((sel == 0 && done0) || (sel != 0 && done2)) begin
                ok = 1'b1;
                break;
            end
        end
        start0 = 1'b0;
        if (!ok) chk({e.name, ":timeout"}, 0, 1);
        @(negedge clk);
        sof0 = 1'b0;
        sof2 = 1'b0;
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        start0 = 0; start2 = 0; abort0 = 0; abort2 = 0; sof0 = 0; sof2 = 0;
        flip0 = '0; flip1 = '0; tie0 = 2'b00; use_delay = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset:dut_in", 32'(in0), 0);
        chk("reset:busy_done_pass", {busy0, done0, pass0}, 0);
        chk("reset:fail_mask", 32'(mask0), 0);
        chk("reset:err_cnt", 32'(err0), 0);
        chk("reset:first_fail", 32'(ff0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean sweep, with a start pulse at vector 10 that must be ignored.
        run(0, mk("clean", 32, 1'b1, 2'b00, 1, 0, 0, 0, 0), 1'b0, 10);

        flip1 = 32'h1 << 5;
        run(0, mk("ch1_v5", 32, 1'b0, 2'b10, 1, 0, 1, 0, 5), 1'b0, -1);

        flip1 = '0; tie0 = 2'b01;
        run(0, mk("ch0_zero", 32, 1'b0, 2'b01, 1, 16, 0, 1, 0), 1'b0, -1);

        // Restart from DONE with clean models: statistics must be wiped.
        tie0 = 2'b00;
        run(0, mk("rerun", 32, 1'b1, 2'b00, 1, 0, 0, 0, 0), 1'b0, -1);

        flip1 = (32'h1 << 7) | (32'h1 << 20);
        run(0, mk("stop_on_fail", 8, 1'b0, 2'b10, 1, 0, 1, 0, 7), 1'b1, -1);

        flip1 = '0; use_delay = 1'b1;
        run(0, mk("lat0_vs_reg", 32, 1'b0, 2'b11, 0, 0, 0, 0, 0), 1'b0, -1);
        use_delay = 1'b0;

        run(2, mk("lat2", 34, 1'b1, 2'b00, 1, 0, 0, 0, 0), 1'b0, -1);

        // Abort while draining the LAT=2 pipeline.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy2 && in2 == 5'd31) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("abort:reach_last", 32'(ok), 1);
        @(negedge clk);
        chk("abort:in_drain", {busy2, done2, in2}, {2'b10, 5'd31});
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        chk("abort:idle", {busy2, done2}, 0);
        repeat (5) @(negedge clk);
        chk("abort:done_stays_low", 32'(done2), 0);

        // Reset in the middle of a failing sweep at vector 12.
        tie0 = 2'b01;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy0 && in0 == 5'd12) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("midreset:reach_12", 32'(ok), 1);
        chk("midreset:err_before", 32'(err0[5:0]), 4);
        chk("midreset:first_before", 32'(ff0[4:0]), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset:dut_in", 32'(in0), 0);
        chk("midreset:flags", {busy0, done0, pass0, mask0}, 0);
        chk("midreset:err_cnt", 32'(err0), 0);
        chk("midreset:first_fail", 32'(ff0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tie0 = 2'b00;
        repeat (2) @(negedge clk);

        chk("queue0_drained", q0.size(), 0);
        chk("queue2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
